// File: rtl/security_access_ctrl_pkg.sv
// security_pkg: shared types and constants for the security access front-end.
//   state_e            controller FSM states
//   DIR_MEM / DIR_REG  request direction encodings (encode / decode path)
//   UNLOCK_KEY_DEFAULT default key value that grants access
package security_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RESP    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic DIR_MEM = 1'b0;
  localparam logic DIR_REG = 1'b1;

  localparam logic [15:0] UNLOCK_KEY_DEFAULT = 16'h0032;

endpackage

// File: rtl/security_access_ctrl_lockout_timer.sv
// sec_lockout_timer: consecutive bad-key counter and timed lockout.
//   clk, rst_n  clock, asynchronous active-low reset
//   bad_key     pulse: a request with a wrong key was accepted
//   good_key    pulse: a request with the correct key was accepted (clears count)
//   start       pulse: begin a lockout of LOCK_CYCLES cycles
//   trip        fail count has reached MAX_FAIL
//   locked      lockout in progress
//   expire      last cycle of the lockout (locked drops on the next edge)
module sec_lockout_timer #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bad_key,
  input  logic good_key,
  input  logic start,
  output logic trip,
  output logic locked,
  output logic expire
);

  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_cnt;

  assign trip   = (fail_cnt == FW'(MAX_FAIL));
  assign expire = locked && (lock_cnt == LW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (start) begin
        locked   <= 1'b1;
        lock_cnt <= LW'(LOCK_CYCLES);
      end else if (locked) begin
        lock_cnt <= lock_cnt - LW'(1);
        if (expire) locked <= 1'b0;
      end

      // Expiry and accepts never coincide: no request is taken while locked.
      if (expire || good_key) begin
        fail_cnt <= '0;
      end else if (bad_key && !trip) begin
        fail_cnt <= fail_cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/security_access_ctrl.sv
// security_access_ctrl: front-end for the data encode/decode transform.
// Accepts one request at a time, checks the caller key, drives the transform
// with exactly one access code for XFORM_LAT cycles, captures the result and
// returns it on a valid/ready response channel. Repeated bad keys lock out.
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_dir, req_data, req_key    direction (0 encode, 1 decode), operand, key
//   sec_data_in                   operand to transform
//   sec_key_mem, sec_key_reg      access codes (only one nonzero, only in XFER)
//   sec_data_out                  transform result
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             captured result (0 on error), key-rejected flag
//   locked                        lockout active
module security_access_ctrl
  import security_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       KEY_W       = 16,
  parameter logic [KEY_W-1:0]  UNLOCK_KEY  = KEY_W'(UNLOCK_KEY_DEFAULT),
  parameter int unsigned       MAX_FAIL    = 3,
  parameter int unsigned       LOCK_CYCLES = 256,
  parameter int unsigned       XFORM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [DATA_W-1:0] req_data,
  input  logic [KEY_W-1:0]  req_key,
  output logic [DATA_W-1:0] sec_data_in,
  output logic [KEY_W-1:0]  sec_key_mem,
  output logic [KEY_W-1:0]  sec_key_reg,
  input  logic [DATA_W-1:0] sec_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              locked
);

  localparam int unsigned XW = $clog2(XFORM_LAT + 1);

  state_e        state;
  logic [XW-1:0] xfer_cnt;

  logic accept, key_ok, trip, expire, lock_start;

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign key_ok     = (req_key == UNLOCK_KEY);
  assign lock_start = (state == RESP) && rsp_ready && trip;

  sec_lockout_timer #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clk      (clk),
    .rst_n    (rst_n),
    .bad_key  (accept && !key_ok),
    .good_key (accept && key_ok),
    .start    (lock_start),
    .trip     (trip),
    .locked   (locked),
    .expire   (expire)
  );

  // req_ready is a registered copy of "next state is IDLE"; it resets low and
  // rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      xfer_cnt    <= '0;
      sec_data_in <= '0;
      sec_key_mem <= '0;
      sec_key_reg <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (key_ok) begin
              sec_data_in <= req_data;
              sec_key_mem <= (req_dir == DIR_MEM) ? UNLOCK_KEY : '0;
              sec_key_reg <= (req_dir == DIR_REG) ? UNLOCK_KEY : '0;
              xfer_cnt    <= XW'(XFORM_LAT - 1);
              state       <= XFER;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        XFER: begin
          if (xfer_cnt == '0) begin
            rsp_data    <= sec_data_out;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
            sec_data_in <= '0;
            sec_key_mem <= '0;
            sec_key_reg <= '0;
            state       <= RESP;
          end else begin
            xfer_cnt <= xfer_cnt - XW'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (trip) begin
              state <= LOCKOUT;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
        end

        LOCKOUT: begin
          if (expire) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
